obi_sram_arbiter: RTL and testbench
===================================

Name: obi_sram_arbiter

Overview:
- Shares one single-ported SRAM macro between NumPorts OBI subordinate ports.
- Arbitration is round-robin with winner lock, so the SRAM-side request stays stable while the macro stalls.
- Drives the raw SRAM request interface (req/we/addr/wdata/be, gnt, rdata) and routes each fixed 1-cycle read/write response back to the port that issued it.
- Sits between an OBI crossbar/demux and the SRAM macro; replaces a per-port shim when ports outnumber macro ports.

Parameters:
- ObiCfg, obi_pkg::ObiDefaultConfig, OBI configuration shared by all ports. UseAtop, UseRReady and Integrity must be 0; elaboration $error otherwise.
- obi_req_t, logic, OBI request struct.
- obi_rsp_t, logic, OBI response struct.
- NumPorts, 2, number of requesting OBI ports; must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- obi_req_i  in  NumPorts x obi_req_t  per-port OBI requests
- obi_rsp_o  out  NumPorts x obi_rsp_t  per-port OBI responses
- req_o  out  1  SRAM request
- we_o  out  1  SRAM write enable
- addr_o  out  ObiCfg.AddrWidth  SRAM address
- wdata_o  out  ObiCfg.DataWidth  SRAM write data
- be_o  out  ObiCfg.DataWidth/8  SRAM byte enables
- gnt_i  in  1  SRAM grant; may be held low to stall
- rdata_i  in  ObiCfg.DataWidth  SRAM read data, valid the cycle after a granted request

Behaviour:
- Index width IdxW = max(1, $clog2(NumPorts)).
- State registers, with reset values:
  - rr_q [IdxW] = 0
  - lock_q = 0
  - lock_idx_q = 0
  - rvalid_q = 0
  - rsel_q [IdxW] = 0
  - rid_q = 0
- Winner selection, combinational:
  - If lock_q=1, winner = lock_idx_q.
  - Otherwise, winner = first port with req=1, searching cyclically from rr_q upward and wrapping at NumPorts-1 -> 0.
- req_o = OR of all port req. we_o, addr_o, wdata_o and be_o are muxed from the winner's a-channel. When no port requests, the SRAM-side outputs show port 0's fields and req_o=0.
- Grant: obi_rsp_o[winner].gnt = gnt_i & req_o. gnt=0 for all other ports.
- Handshake: a transfer occurs when req_o & gnt_i.
  - On transfer: rr_q <= winner+1, wrapping to 0 after NumPorts-1; lock_q <= 0.
  - If req_o & !gnt_i: lock_q <= 1 and lock_idx_q <= winner. Same port, same address until granted.
- Response path, fixed latency 1:
  - On transfer: rvalid_q <= 1, rsel_q <= winner, rid_q <= winner's aid.
  - Otherwise: rvalid_q <= 0.
  - obi_rsp_o[i].rvalid = rvalid_q & (rsel_q == i).
  - All ports see rdata = rdata_i, rid = rid_q, err = 0.
- Back-to-back transfers are allowed every cycle. A response and a new grant may coincide, on the same port or different ports.
- Locked port deasserting req (OBI protocol violation): the lock is released the next cycle, and the cycle's req_o follows the OR of live requests.
- NumPorts=1: degenerates to plain shim behaviour; rr_q stays 0.
- Reset asserted mid-operation: all state clears immediately and any in-flight rvalid is dropped. Upstream must be reset together with this block.
- Prot and memtype are passed through unchecked; elaboration $warning if enabled.

Decomposition:
- No new package entries. Use obi_pkg::obi_cfg_t; IdxW is a localparam.
- One natural sub-module, obi_sram_rr_sel: combinational round-robin first-one search returning winner index and valid from the req vector and rr_q.
- Lock, rr pointer and response registers stay in the top module.

Test Plan:
- Single port 1 write, addr 0x40, wdata 0xDEADBEEF, be 0xF, gnt_i=1 -> gnt[1]=1 same cycle; next cycle rvalid[1]=1, rid = issued aid, err=0; rr_q=0 (NumPorts=2).
- Ports 0 and 1 both requesting continuously, gnt_i=1, rr_q=0 -> grants alternate 0,1,0,1 across 4 cycles; rvalid follows each grant one cycle later on the matching port.
- Port 0 requests addr 0x10, gnt_i=0 for 3 cycles, port 1 raises req in cycle 2 -> addr_o stays 0x10 and gnt[1]=0 throughout; gnt_i=1 in cycle 4 grants port 0; port 1 granted in cycle 5.
- NumPorts=3, only ports 0 and 2 requesting, rr_q=1 -> port 2 wins, rr_q becomes 0, then port 0 wins; wrap-around verified.
- Read of addr 0x80 from port 1 with aid=5, rdata_i=0x12345678 the following cycle -> obi_rsp_o[1].rdata=0x12345678, rid=5, rvalid[0]=0.
- Assert rst_ni low while locked with rvalid_q=1 -> rvalid and lock cleared immediately; after release, rr_q=0 and port 0 wins first.

Source files
------------

// File: rtl/obi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : obi_pkg
// Brief    : OBI configuration type, default configuration and default
//            request/response structs used by the SRAM arbiter.
// Revision : 1.0
// ============================================================================
package obi_pkg;

  typedef struct packed {
    bit UseAtop;
    bit UseMemtype;
    bit UseProt;
  } obi_optional_cfg_t;

  typedef struct packed {
    bit                UseRReady;
    bit                CombGnt;
    int unsigned       AddrWidth;
    int unsigned       DataWidth;
    int unsigned       IdWidth;
    bit                Integrity;
    bit                BeFull;
    obi_optional_cfg_t OptionalCfg;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    UseRReady:   1'b0,
    CombGnt:     1'b0,
    AddrWidth:   32,
    DataWidth:   32,
    IdWidth:     1,
    Integrity:   1'b0,
    BeFull:      1'b1,
    OptionalCfg: '{UseAtop: 1'b0, UseMemtype: 1'b0, UseProt: 1'b0}
  };

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } obi_default_a_chan_t;

  typedef struct packed {
    logic                req;
    obi_default_a_chan_t a;
  } obi_default_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } obi_default_r_chan_t;

  typedef struct packed {
    logic                gnt;
    logic                rvalid;
    obi_default_r_chan_t r;
  } obi_default_rsp_t;

endpackage
`default_nettype wire

// File: rtl/obi_sram_arbiter_rr_sel.sv
`default_nettype none
// ============================================================================
// Module   : obi_sram_rr_sel
// Brief    : Combinational round-robin first-one search starting at rr_i.
// Revision : 1.0
// ============================================================================
module obi_sram_rr_sel #(
  parameter int unsigned NumPorts = 2,
  parameter int unsigned IdxW     = 1
) (
  input  logic [NumPorts-1:0] req_i,
  input  logic [IdxW-1:0]     rr_i,
  output logic [IdxW-1:0]     idx_o,
  output logic                valid_o
);

  int unsigned         cand;
  logic [NumPorts-1:0] shifted;
  logic                found;

  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    cand    = 0;
    shifted = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      cand = 32'(rr_i) + k;
      if (cand >= NumPorts) begin
        cand = cand - NumPorts;
      end
      shifted = req_i >> cand;
      if (!found && shifted[0]) begin
        idx_o = IdxW'(cand);
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/obi_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : obi_sram_arbiter
// Brief    : Round-robin arbiter sharing one single-ported SRAM between
//            NumPorts OBI ports, with winner lock and 1-cycle responses.
// Revision : 1.0
// ============================================================================
module obi_sram_arbiter
  import obi_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg    = ObiDefaultConfig,
  parameter type         obi_req_t = obi_default_req_t,
  parameter type         obi_rsp_t = obi_default_rsp_t,
  parameter int unsigned NumPorts  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  obi_req_t [NumPorts-1:0]       obi_req_i,
  output obi_rsp_t [NumPorts-1:0]       obi_rsp_o,
  output logic                          req_o,
  output logic                          we_o,
  output logic [ObiCfg.AddrWidth-1:0]   addr_o,
  output logic [ObiCfg.DataWidth-1:0]   wdata_o,
  output logic [ObiCfg.DataWidth/8-1:0] be_o,
  input  logic                          gnt_i,
  input  logic [ObiCfg.DataWidth-1:0]   rdata_i
);

  localparam int unsigned     IdxW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumPorts - 1);

  if (NumPorts < 1) begin : g_bad_numports
    $error("obi_sram_arbiter: NumPorts must be >= 1");
  end
  if (ObiCfg.OptionalCfg.UseAtop || ObiCfg.UseRReady || ObiCfg.Integrity) begin : g_bad_cfg
    $error("obi_sram_arbiter: UseAtop, UseRReady and Integrity are not supported");
  end
  if (ObiCfg.OptionalCfg.UseProt || ObiCfg.OptionalCfg.UseMemtype) begin : g_prot_warn
    $warning("obi_sram_arbiter: prot/memtype are not forwarded to the SRAM");
  end

  logic [IdxW-1:0]           rr_q, rr_d;
  logic                      lock_q, lock_d;
  logic [IdxW-1:0]           lock_idx_q, lock_idx_d;
  logic                      rvalid_q, rvalid_d;
  logic [IdxW-1:0]           rsel_q, rsel_d;
  logic [ObiCfg.IdWidth-1:0] rid_q, rid_d;

  logic [NumPorts-1:0] port_req;
  logic [IdxW-1:0]     sel_idx;
  logic                sel_valid;
  logic                use_lock;
  logic [IdxW-1:0]     winner;
  logic                xfer;

  always_comb begin
    port_req = '0;
    for (int p = 0; p < NumPorts; p++) begin
      port_req[p] = obi_req_i[p].req;
    end
  end

  obi_sram_rr_sel #(
    .NumPorts (NumPorts),
    .IdxW     (IdxW)
  ) i_rr_sel (
    .req_i   (port_req),
    .rr_i    (rr_q),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  // A lock only holds while its port keeps requesting; a dropped request
  // falls back to the round-robin choice among the live requests.
  assign use_lock = lock_q & port_req[lock_idx_q];
  assign winner   = use_lock ? lock_idx_q : sel_idx;
  assign req_o    = sel_valid;
  assign xfer     = req_o & gnt_i;

  assign we_o    = obi_req_i[winner].a.we;
  assign addr_o  = obi_req_i[winner].a.addr;
  assign wdata_o = obi_req_i[winner].a.wdata;
  assign be_o    = obi_req_i[winner].a.be;

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rvalid_d   = xfer;
    rsel_d     = rsel_q;
    rid_d      = rid_q;
    if (xfer) begin
      rr_d   = (winner == LastIdx) ? '0 : winner + 1'b1;
      lock_d = 1'b0;
      rsel_d = winner;
      rid_d  = obi_req_i[winner].a.aid;
    end else if (req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = winner;
    end else begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      rvalid_q   <= 1'b0;
      rsel_q     <= '0;
      rid_q      <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rvalid_q   <= rvalid_d;
      rsel_q     <= rsel_d;
      rid_q      <= rid_d;
    end
  end

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      obi_rsp_o[p]         = '0;
      obi_rsp_o[p].gnt     = xfer & (winner == IdxW'(p));
      obi_rsp_o[p].rvalid  = rvalid_q & (rsel_q == IdxW'(p));
      obi_rsp_o[p].r.rdata = rdata_i;
      obi_rsp_o[p].r.rid   = rid_q;
      obi_rsp_o[p].r.err   = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obi_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_sram_arbiter
// Brief    : Self-checking bench for obi_sram_arbiter (3 ports) with directed
//            scenarios, randomized traffic and asynchronous reset.
// Revision : 1.0
// ============================================================================
module tb_obi_sram_arbiter;
  import obi_pkg::*;

  localparam int NP = 3;
  localparam obi_cfg_t Cfg = '{
    UseRReady: 1'b0, CombGnt: 1'b0, AddrWidth: 32, DataWidth: 32, IdWidth: 4,
    Integrity: 1'b0, BeFull: 1'b1,
    OptionalCfg: '{UseAtop: 1'b0, UseMemtype: 1'b0, UseProt: 1'b0}
  };

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } a_t;
  typedef struct packed { logic req; a_t a; } req_t;
  typedef struct packed { logic [31:0] rdata; logic [3:0] rid; logic err; } r_t;
  typedef struct packed { logic gnt; logic rvalid; r_t r; } rsp_t;

  logic            clk;
  logic            rst_ni;
  req_t [NP-1:0]   req_i;
  rsp_t [NP-1:0]   rsp_o;
  logic            req_o, we_o, gnt_i;
  logic [31:0]     addr_o, wdata_o, rdata_i;
  logic [3:0]      be_o;

  obi_sram_arbiter #(
    .ObiCfg    (Cfg),
    .obi_req_t (req_t),
    .obi_rsp_t (rsp_t),
    .NumPorts  (NP)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .obi_req_i (req_i),
    .obi_rsp_o (rsp_o),
    .req_o     (req_o),
    .we_o      (we_o),
    .addr_o    (addr_o),
    .wdata_o   (wdata_o),
    .be_o      (be_o),
    .gnt_i     (gnt_i),
    .rdata_i   (rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: rotating priority pointer, pending (stalled) port and
  // the port owed a response next cycle.
  int         ptr, pend, rv_port;
  logic [3:0] rv_id;

  req_t        b_port [NP];
  logic        b_gnt;
  logic [31:0] b_rdata;
  bit          granted_last [NP];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    ptr = 0; pend = -1; rv_port = -1; rv_id = '0;
    for (int p = 0; p < NP; p++) granted_last[p] = 1'b0;
  endtask

  task automatic clear_ports();
    for (int p = 0; p < NP; p++) b_port[p] = '0;
    b_gnt = 1'b0;
  endtask

  task automatic set_port(input int p, input logic [31:0] addr, input logic we,
                          input logic [31:0] wd, input logic [3:0] be, input logic [3:0] aid);
    b_port[p].req     = 1'b1;
    b_port[p].a.addr  = addr;
    b_port[p].a.we    = we;
    b_port[p].a.wdata = wd;
    b_port[p].a.be    = be;
    b_port[p].a.aid   = aid;
  endtask

  // One cycle, entered and left at the falling edge.
  task automatic step();
    int  w, idx;
    bit  any, found;
    for (int p = 0; p < NP; p++) req_i[p] = b_port[p];
    gnt_i   = b_gnt;
    rdata_i = b_rdata;
    #1;
    any = 1'b0; w = 0; found = 1'b0;
    for (int p = 0; p < NP; p++) any |= b_port[p].req;
    if (pend >= 0 && b_port[pend].req) begin
      w = pend;
    end else if (any) begin
      for (int k = 0; k < NP; k++) begin
        idx = (ptr + k) % NP;
        if (!found && b_port[idx].req) begin
          w = idx; found = 1'b1;
        end
      end
    end
    check_eq("req_o", req_o, any);
    check_eq("addr_o", addr_o, b_port[w].a.addr);
    check_eq("we_o", we_o, b_port[w].a.we);
    check_eq("wdata_o", wdata_o, b_port[w].a.wdata);
    check_eq("be_o", be_o, b_port[w].a.be);
    for (int p = 0; p < NP; p++) begin
      check_eq($sformatf("gnt%0d", p), rsp_o[p].gnt, any && b_gnt && (w == p));
      check_eq($sformatf("rvalid%0d", p), rsp_o[p].rvalid, rv_port == p);
      if (rv_port == p) begin
        check_eq($sformatf("rid%0d", p), rsp_o[p].r.rid, rv_id);
        check_eq($sformatf("rdata%0d", p), rsp_o[p].r.rdata, b_rdata);
        check_eq($sformatf("err%0d", p), rsp_o[p].r.err, 1'b0);
      end
    end
    @(posedge clk);
    if (any && b_gnt) begin
      ptr = (w + 1) % NP; pend = -1; rv_port = w; rv_id = b_port[w].a.aid;
    end else begin
      rv_port = -1;
      pend = any ? w : -1;
    end
    for (int p = 0; p < NP; p++) granted_last[p] = any && b_gnt && (w == p);
    @(negedge clk);
  endtask

  // Called at a falling edge; reset is asserted mid-cycle.
  task automatic async_reset();
    #2;
    rst_ni = 1'b0;
    #1;
    for (int p = 0; p < NP; p++)
      check_eq($sformatf("rst_rvalid%0d", p), rsp_o[p].rvalid, 1'b0);
    clear_ports();
    for (int p = 0; p < NP; p++) req_i[p] = '0;
    gnt_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    for (int p = 0; p < NP; p++) req_i[p] = '0;
    gnt_i = 1'b0; rdata_i = '0; b_rdata = '0;
    clear_ports();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_req_o", req_o, 1'b0);
    for (int p = 0; p < NP; p++) begin
      check_eq($sformatf("reset_gnt%0d", p), rsp_o[p].gnt, 1'b0);
      check_eq($sformatf("reset_rvalid%0d", p), rsp_o[p].rvalid, 1'b0);
    end
    @(negedge clk);
    rst_ni = 1'b1;

    // Lone write from port 1, then its response.
    set_port(1, 32'h40, 1'b1, 32'hDEADBEEF, 4'hF, 4'd3);
    b_gnt = 1'b1;
    step();
    clear_ports();
    step();

    // Two ports contending with continuous grant.
    set_port(0, 32'h100, 1'b0, 32'h0, 4'hF, 4'd1);
    set_port(1, 32'h200, 1'b0, 32'h0, 4'hF, 4'd2);
    b_gnt = 1'b1;
    repeat (4) begin b_rdata = $urandom; step(); end
    clear_ports();
    step();

    // Stall: port 0 held at 0x10, port 1 joins, grants resume.
    set_port(0, 32'h10, 1'b0, 32'h0, 4'hF, 4'd4);
    step();
    set_port(1, 32'h20, 1'b1, 32'h5555AAAA, 4'h3, 4'd6);
    step();
    step();
    b_gnt = 1'b1;
    step();
    b_port[0].req = 1'b0;
    step();
    clear_ports();
    step();

    // Wrap-around: pointer at 1 with ports 0 and 2 requesting.
    set_port(0, 32'h300, 1'b0, 32'h0, 4'hF, 4'd7);
    b_gnt = 1'b1;
    step();
    set_port(2, 32'h400, 1'b1, 32'h01020304, 4'hC, 4'd8);
    step();
    step();
    clear_ports();
    step();

    // Read with id 5 and the returned data.
    set_port(1, 32'h80, 1'b0, 32'h0, 4'hF, 4'd5);
    b_gnt = 1'b1;
    step();
    clear_ports();
    b_rdata = 32'h12345678;
    step();

    // Randomized traffic; a stalled port holds its request.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!(b_port[p].req && !granted_last[p])) begin
          if ($urandom_range(0, 99) < 55) begin
            set_port(p, $urandom, 1'($urandom_range(0, 1)), $urandom,
                     4'($urandom), 4'($urandom));
          end else begin
            b_port[p].req = 1'b0;
          end
        end
      end
      b_gnt   = ($urandom_range(0, 99) < 65);
      b_rdata = $urandom;
      step();
    end
    clear_ports();
    step();

    // Reset with a response in flight.
    set_port(2, 32'h500, 1'b0, 32'h0, 4'hF, 4'd9);
    b_gnt = 1'b1;
    step();
    clear_ports();
    #1;
    check_eq("pre_rst_rvalid2", rsp_o[2].rvalid, rv_port == 2);
    async_reset();

    // Reset while locked with the pointer advanced.
    set_port(0, 32'h600, 1'b0, 32'h0, 4'hF, 4'd1);
    b_gnt = 1'b1;
    step();
    clear_ports();
    set_port(2, 32'h700, 1'b0, 32'h0, 4'hF, 4'd2);
    step();
    async_reset();
    set_port(0, 32'h800, 1'b0, 32'h0, 4'hF, 4'd3);
    set_port(1, 32'h900, 1'b0, 32'h0, 4'hF, 4'd4);
    set_port(2, 32'hA00, 1'b0, 32'h0, 4'hF, 4'd5);
    b_gnt = 1'b1;
    step();
    clear_ports();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
